// File: rtl/alu_pkg.sv
// Shared types and Hack function encodings for the pipelined ALU.
package alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ZERO  = 6'b101010;
  localparam alu_ctrl_t ALU_ONE   = 6'b111111;
  localparam alu_ctrl_t ALU_NEG1  = 6'b111010;
  localparam alu_ctrl_t ALU_X     = 6'b001100;
  localparam alu_ctrl_t ALU_Y     = 6'b110000;
  localparam alu_ctrl_t ALU_NOTX  = 6'b001101;
  localparam alu_ctrl_t ALU_NOTY  = 6'b110001;
  localparam alu_ctrl_t ALU_NEGX  = 6'b001111;
  localparam alu_ctrl_t ALU_NEGY  = 6'b110011;
  localparam alu_ctrl_t ALU_XP1   = 6'b011111;
  localparam alu_ctrl_t ALU_YP1   = 6'b110111;
  localparam alu_ctrl_t ALU_XM1   = 6'b001110;
  localparam alu_ctrl_t ALU_YM1   = 6'b110010;
  localparam alu_ctrl_t ALU_XPY   = 6'b000010;
  localparam alu_ctrl_t ALU_XMY   = 6'b010011;
  localparam alu_ctrl_t ALU_YMX   = 6'b000111;
  localparam alu_ctrl_t ALU_XANDY = 6'b000000;
  localparam alu_ctrl_t ALU_XORY  = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational back half of the Hack ALU: add/and, optional inversion, flags.
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xp_i,
  input  logic [WIDTH-1:0] yp_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             co_o,
  output logic             ov_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  always_comb begin
    sum   = {1'b0, xp_i} + {1'b0, yp_i};
    r     = f_i ? sum[WIDTH-1:0] : (xp_i & yp_i);
    out_o = no_i ? ~r : r;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
    // Adder flags ignore the output inversion and mean nothing for AND.
    co_o  = f_i & sum[WIDTH];
    ov_o  = f_i & (xp_i[WIDTH-1] == yp_i[WIDTH-1]) & (sum[WIDTH-1] != xp_i[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready Hack ALU: stage 1 conditions operands, stage 2 holds results.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             co,
  output logic             ov
);

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] xp_q, yp_q, xp_d, yp_d;
  logic             f_q, no_q;
  logic [WIDTH-1:0] out_q, core_out;
  logic             zr_q, ng_q, co_q, ov_q;
  logic             core_zr, core_ng, core_co, core_ov;
  logic             accept, s2_adv;

  // Stage 2 takes a new beat when empty or when its current beat drains.
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    xp_d = ctrl.zx ? '0 : x;
    xp_d = ctrl.nx ? ~xp_d : xp_d;
    yp_d = ctrl.zy ? '0 : y;
    yp_d = ctrl.ny ? ~yp_d : yp_d;

    s1_valid_d = s1_valid_q;
    if (accept)      s1_valid_d = 1'b1;
    else if (s2_adv) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_adv)         s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .xp_i (xp_q),
    .yp_i (yp_q),
    .f_i  (f_q),
    .no_i (no_q),
    .out_o(core_out),
    .zr_o (core_zr),
    .ng_o (core_ng),
    .co_o (core_co),
    .ov_o (core_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      xp_q       <= '0;
      yp_q       <= '0;
      f_q        <= 1'b0;
      no_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        xp_q <= xp_d;
        yp_q <= yp_d;
        f_q  <= ctrl.f;
        no_q <= ctrl.no;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      co_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_adv) begin
        out_q <= core_out;
        zr_q  <= core_zr;
        ng_q  <= core_ng;
        co_q  <= core_co;
        ov_q  <= core_ov;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign co        = co_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: function set, flags, backpressure, reset, WIDTH=8.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, out;
  alu_ctrl_t   ctrl;
  logic        zr, ng, co, ov;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  x8, y8, out8;
  alu_ctrl_t   ctrl8;
  logic        zr8, ng8, co8, ov8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .co(co), .ov(ov)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zr(zr8), .ng(ng8), .co(co8), .ov(ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for a single cycle, then wait for it to reach stage 2.
  task automatic run1(input alu_ctrl_t c, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; ctrl = c; x = a; y = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; ctrl = ALU_ZERO;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0; ctrl8 = ALU_ZERO;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0);
    chk("rst_flags", {zr, ng, co, ov}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Back-to-back XPY, XMY, YMX with x=5, y=3
    in_valid = 1'b1; x = 16'd5; y = 16'd3; ctrl = ALU_XPY;
    tick();
    chk("lat_not_yet", out_valid, 1'b0);
    ctrl = ALU_XMY;
    tick();
    ctrl = ALU_YMX;
    chk("b2b_v0", out_valid, 1'b1);
    chk("b2b_xpy", out, 16'd8);
    chk("b2b_ng0", ng, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("b2b_v1", out_valid, 1'b1);
    chk("b2b_xmy", out, 16'd2);
    chk("b2b_ng1", ng, 1'b0);
    tick();
    chk("b2b_v2", out_valid, 1'b1);
    chk("b2b_ymx", out, 16'hFFFE);
    chk("b2b_ng2", ng, 1'b1);
    tick();
    chk("b2b_drained", out_valid, 1'b0);

    run1(ALU_ZERO, 16'h1234, 16'h0000);
    chk("zero_v", out_valid, 1'b1);
    chk("zero_out", out, 16'h0);
    chk("zero_flags", {zr, ng, co, ov}, 4'b1000);

    run1(ALU_NEG1, 16'h0000, 16'h0000);
    chk("neg1_out", out, 16'hFFFF);
    chk("neg1_zr_ng", {zr, ng}, 2'b01);

    run1(ALU_XPY, 16'h7FFF, 16'h0001);
    chk("ovf_out", out, 16'h8000);
    chk("ovf_flags", {zr, ng, co, ov}, 4'b0101);

    run1(ALU_XPY, 16'hFFFF, 16'h0001);
    chk("carry_out", out, 16'h0);
    chk("carry_flags", {zr, ng, co, ov}, 4'b1010);

    run1(ALU_XANDY, 16'hFFFF, 16'hFFFF);
    chk("and_out", out, 16'hFFFF);
    chk("and_co_ov", {co, ov}, 2'b00);
    tick();

    // Backpressure: ALU_X beats 1..4 with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl = ALU_X; y = 16'h5555; x = 16'd1;
    chk("bp_rdy1", in_ready, 1'b1);
    tick();
    x = 16'd2;
    chk("bp_rdy2", in_ready, 1'b1);
    tick();
    x = 16'd3;
    chk("bp_full", in_ready, 1'b0);
    chk("bp_v", out_valid, 1'b1);
    chk("bp_out1", out, 16'd1);
    tick();
    chk("bp_full_hold", in_ready, 1'b0);
    chk("bp_out1_hold", out, 16'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", in_ready, 1'b1);
    tick();
    x = 16'd4;
    chk("bp_out2", out, 16'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_out3", out, 16'd3);
    tick();
    chk("bp_v4", out_valid, 1'b1);
    chk("bp_out4", out, 16'd4);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // Reset with two beats in flight
    in_valid = 1'b1; ctrl = ALU_X; x = 16'd7;
    tick();
    x = 16'd8;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", out_valid, 1'b0);
    chk("mid_rst_out", out, 16'h0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("no_stale_a", out_valid, 1'b0);
    tick();
    chk("no_stale_b", out_valid, 1'b0);
    in_valid = 1'b1; x = 16'd9; ctrl = ALU_X;
    tick();
    in_valid = 1'b0;
    chk("rst_lat", out_valid, 1'b0);
    tick();
    chk("rst_next_v", out_valid, 1'b1);
    chk("rst_next_out", out, 16'd9);

    // WIDTH=8: 0x80 - 1 overflows to 0x7F
    in_valid8 = 1'b1; ctrl8 = ALU_XMY; x8 = 8'h80; y8 = 8'h01;
    tick();
    in_valid8 = 1'b0;
    tick();
    chk("w8_v", out_valid8, 1'b1);
    chk("w8_out", out8, 8'h7F);
    chk("w8_flags", {zr8, ng8, co8, ov8}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
